// File: rtl/spi_arbiter.sv
// Round-robin arbiter and transfer sequencer for a three-slave SPI shift datapath.
// Grants one requester at a time, loads its word, selects its slave for DW shifts, then returns the exchanged byte.
module spi_arbiter #(
    parameter int DW = 8
) (
    input  logic          sclk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    input  logic [DW-1:0] miso_q,
    output logic          load,
    output logic [DW-1:0] datain,
    output logic          ss0,
    output logic          ss1,
    output logic          ss2,
    output logic [2:0]    gnt,
    output logic          busy,
    output logic [2:0]    done,
    output logic [DW-1:0] rdata
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt_q;
    logic          load_q;
    logic [DW-1:0] datain_q;
    logic [2:0]    ss_q;
    logic [2:0]    gnt_q;
    logic          busy_q;
    logic [2:0]    done_q;
    logic [DW-1:0] rdata_q;

    logic          winValid_d;
    logic [1:0]    win_d;
    logic [1:0]    cand_d;
    logic [DW-1:0] wsel_d;

    // Search starts at the pointer and wraps modulo 3; the first pending request wins.
    always_comb begin
        winValid_d = 1'b0;
        win_d      = 2'd0;
        cand_d     = ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (!winValid_d && req[cand_d]) begin
                winValid_d = 1'b1;
                win_d      = cand_d;
            end
            cand_d = (cand_d == 2'd2) ? 2'd0 : cand_d + 2'd1;
        end
    end

    always_comb begin
        case (win_d)
            2'd0:    wsel_d = wdata0;
            2'd1:    wsel_d = wdata1;
            default: wsel_d = wdata2;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            sel_q    <= 2'd0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            datain_q <= '0;
            ss_q     <= 3'b111;
            gnt_q    <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 3'b000;
            rdata_q  <= '0;
        end else begin
            done_q <= 3'b000;
            case (state_q)
                IDLE: begin
                    if (winValid_d) begin
                        sel_q    <= win_d;
                        datain_q <= wsel_d;
                        gnt_q    <= 3'b001 << win_d;
                        load_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    // Select goes low only once load has dropped, so the two never overlap.
                    load_q  <= 1'b0;
                    ss_q    <= ~(3'b001 << sel_q);
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        ss_q    <= 3'b111;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rdata_q <= miso_q;
                    done_q  <= 3'b001 << sel_q;
                    gnt_q   <= 3'b000;
                    busy_q  <= 1'b0;
                    ptr_q   <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load   = load_q;
    assign datain = datain_q;
    assign ss0    = ss_q[0];
    assign ss1    = ss_q[1];
    assign ss2    = ss_q[2];
    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Sequencing controller and round-robin arbiter for the three-slave SPI shift datapath. Three requesters each submit an 8-bit word; the block grants one at a time, parallel-loads the master shift register, asserts exactly one active-low slave select for eight shift clocks, then returns the exchanged byte to the winning requester. It sits directly between the requester logic and the SPI datapath, and is the only driver of the datapath's `load`, `datain` and `ss0`..`ss2` inputs.

## Interface

- `DW`, default 8: data width. Must equal the datapath shift-register width. It also sets the shift count per transfer.
- `sclk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  3  per-requester request; bit k = requester k, which targets slave k+1 (select line `ss`k).
- `wdata0`, `wdata1`, `wdata2`  in  DW  per-requester transmit word; sampled only at the grant edge.
- `miso_q`  in  DW  master shift-register contents from the datapath (its `MISO` output).
- `load`  out  1  active-high parallel-load strobe to the datapath.
- `datain`  out  DW  word to be loaded into the datapath.
- `ss0`, `ss1`, `ss2`  out  1 each  active-low slave selects to the datapath. At most one is low at any time.
- `gnt`  out  3  one-hot grant, held from grant through end of transfer.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  3  one-cycle pulse on bit k when requester k's transfer completes.
- `rdata`  out  DW  received word; valid from the `done` pulse until the next `done`.

## Operation

- All outputs are registered.
- Reset values: state=IDLE, `load`=0, `datain`=0, `ss0`=`ss1`=`ss2`=1, `gnt`=0, `busy`=0, `done`=0, `rdata`=0, round-robin pointer=0, shift counter=0.
- Reset asserted mid-transfer forces all of the above immediately (asynchronously). The transfer is abandoned and no `done` is issued.
- State machine:
  - **IDLE**: if `req`≠0, select the winner k, latch `wdata`k into `datain`, set `gnt[k]`, set `load`=1, and go to LOAD. Otherwise remain in IDLE.
  - **LOAD**: `load`=1 for exactly one cycle. At the next edge, clear `load`, drive `ss`k low, clear the counter, and go to SHIFT.
  - **SHIFT**: `ss`k stays low. The counter increments each edge. At the edge where counter=DW-1, drive `ss`k high and go to DONE.
  - **DONE**: at the next edge, `rdata`←`miso_q`, `done[k]`=1, `gnt`=0, pointer←(k+1) mod 3, and go to IDLE.
- Round robin: the search starts at the pointer and proceeds pointer, pointer+1, pointer+2 (mod 3). The first set `req` bit wins.
- Requests are level-sensitive. Deasserting `req[k]` after the grant does not abort the transfer; `done[k]` still pulses.
- `req[k]` still high at the edge following `done[k]` is treated as a new request and enters arbitration normally.
- `wdata` changes after the grant edge have no effect on the current transfer.
- `load` and a low `ss` are never asserted in the same cycle.

## Timing

- Edge E0: request sampled in IDLE.
- E1: datapath loads `datain`.
- E2..E(DW+1): DW datapath shifts. For DW=8, that is E2..E9.
- E(DW+2): `rdata` and `done` update.
- E(DW+3): the earliest next grant is sampled.
- Transfer period is DW+3 cycles; 11 cycles for DW=8. Back-to-back grants have no extra idle gap.
- `ss`k is low for exactly DW consecutive cycles.
- `done` width is exactly 1 cycle.
- `busy` rises the cycle after E0 and falls at E(DW+2).

## Test plan

- After reset, pulse `req`=001 with `wdata0`=A5 → one `load` pulse, `ss0` low for 8 cycles, then `done`=001 with `rdata`=00. Slave 1 register now holds A5.
- Then `req`=001 with `wdata0`=11 → `rdata`=A5 and slave 1 holds 11. This verifies the full exchange.
- After reset, hold `req`=111 with `wdata0/1/2`=01/02/03 → grant order 0,1,2,0…; `done` pulses 11 cycles apart; slaves 1/2/3 hold 01/02/03.
- Hold `req`=101 continuously → grants alternate 0,2,0,2; requester 1 is never granted; `ss1` stays high throughout.
- Assert `reset` low on the 4th SHIFT cycle of a requester-1 transfer → `ss1` goes high immediately; `gnt`, `busy`, `done` read 0; no `done` after reset release; the next request is granted to requester 0 first.
- Drop `req[2]` during SHIFT and change `wdata2` from 3C to FF after the grant → transfer still completes; slave 3 receives 3C; `done`=100 pulses once.
- Throughout all tests, check that at most one `ss` is low and that `load` is never high while any `ss` is low.
